// File: rtl/spi_pkg.sv
// Shared types for the SPI master: FSM state encoding, {CPOL,CPHA} mode codes
// and a constant ceil-log2 helper used to size counters.
package spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } spi_state_t;

    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/spi_clk_gen.sv
// Half-period timer: one-cycle tick every HALF_DIV clk cycles while enabled.
// Latency: first tick HALF_DIV cycles after enable rises; counter clears whenever disabled.
module spi_clk_gen
    import spi_pkg::*;
#(
    parameter int HALF_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rstb,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (clog2(HALF_DIV + 1) < 1) ? 1 : clog2(HALF_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Wrapping at the tick doubles as the per-state clear, since every state change lands on a tick.
    always_ff @(posedge i_clk or negedge i_rstb) begin
        if (!i_rstb) begin
            r_cnt <= '0;
        end else if (!i_en || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/spi_master.sv
// Single-clock SPI master: one DATA_WIDTH-bit MSB-first frame per accepted start, all CPOL/CPHA modes.
// csb low for (2*DATA_WIDTH+2)*HALF_DIV cycles; start is ignored while busy; all outputs registered.
module spi_master
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int HALF_DIV   = 4
) (
    input  logic                  clk,
    input  logic                  rstb,
    input  logic                  CPOL,
    input  logic                  CPHA,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] datai,
    output logic [DATA_WIDTH-1:0] datao,
    output logic                  busy,
    output logic                  done,
    output logic                  sclk,
    output logic                  csb,
    output logic                  dout,
    input  logic                  din
);

    localparam int EW = clog2(2 * DATA_WIDTH + 1);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

    spi_state_t            r_state;
    logic [1:0]            r_mode;
    logic [DATA_WIDTH-1:0] r_tx;
    logic [DATA_WIDTH-1:0] r_rx;
    logic [DATA_WIDTH-1:0] r_datao;
    logic [EW-1:0]         r_edge_cnt;
    logic                  r_csb;
    logic                  r_sclk;
    logic                  r_dout;
    logic                  r_busy;
    logic                  r_done;

    logic w_tick;
    logic w_cg_en;
    logic w_odd_edge;
    logic w_cpha0;
    logic w_sample;

    assign w_cg_en    = (r_state != ST_IDLE);
    assign w_odd_edge = ~r_edge_cnt[0];
    assign w_sample   = (w_odd_edge == w_cpha0);

    always_comb begin
        w_cpha0 = 1'b0;
        case (r_mode)
            MODE0, MODE2: w_cpha0 = 1'b1;
            MODE1, MODE3: w_cpha0 = 1'b0;
        endcase
    end

    spi_clk_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_clk_gen (
        .i_clk  (clk),
        .i_rstb (rstb),
        .i_en   (w_cg_en),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state    <= ST_IDLE;
            r_mode     <= MODE0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_datao    <= '0;
            r_edge_cnt <= '0;
            r_csb      <= 1'b1;
            r_sclk     <= 1'b0;
            r_dout     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_csb  <= 1'b1;
                    r_sclk <= CPOL;
                    if (start) begin
                        r_mode     <= {CPOL, CPHA};
                        r_tx       <= datai;
                        r_rx       <= '0;
                        r_edge_cnt <= '0;
                        r_csb      <= 1'b0;
                        r_busy     <= 1'b1;
                        if (!CPHA) r_dout <= datai[DATA_WIDTH-1];
                        r_state    <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_sclk <= r_mode[1];
                    if (w_tick) begin
                        r_edge_cnt <= '0;
                        r_state    <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (w_tick) begin
                        r_sclk     <= ~r_sclk;
                        r_edge_cnt <= r_edge_cnt + 1'b1;
                        if (w_sample) begin
                            r_rx <= {r_rx[DATA_WIDTH-2:0], din};
                        end else if (!w_cpha0) begin
                            r_dout <= r_tx[DATA_WIDTH-1];
                            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                        end else if (r_edge_cnt != LAST_EDGE) begin
                            // MSB was already on the wire at csb fall, so the trailing edge presents the next bit.
                            r_dout <= r_tx[DATA_WIDTH-2];
                            r_tx   <= {r_tx[DATA_WIDTH-2:0], 1'b0};
                        end
                        if (r_edge_cnt == LAST_EDGE) begin
                            r_edge_cnt <= '0;
                            r_state    <= ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    r_sclk <= r_mode[1];
                    if (w_tick) begin
                        r_csb      <= 1'b1;
                        r_done     <= 1'b1;
                        r_datao    <= r_rx;
                        r_edge_cnt <= '0;
                        r_state    <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_sclk <= CPOL;
                    if (w_tick) begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign datao = r_datao;
    assign busy  = r_busy;
    assign done  = r_done;
    assign sclk  = r_sclk;
    assign csb   = r_csb;
    assign dout  = r_dout;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: loopback, a behavioural slave in all four modes, back-to-back,
// ignored starts, mid-frame reset, and a HALF_DIV=1 instance with din tied.
module tb_spi_master;

    logic        clk;
    logic        rstb;
    logic        CPOL, CPHA, start;
    logic [15:0] datai;
    logic [15:0] datao;
    logic        busy, done, sclk, csb, dout, din;

    logic        start1, din1;
    logic [15:0] datai1, datao1;
    logic        busy1, done1, sclk1, csb1, dout1;

    logic        din_sel;
    logic        s_cpha;
    logic [15:0] slave_word;
    logic [15:0] s_tx, s_rx;
    logic        s_din;
    int          s_edges;
    logic        prev_csb  = 1'b1;
    logic        prev_sclk = 1'b0;

    int done_cnt = 0, low_cnt = 0, hi_cnt = 0, rise_cnt = 0, fall_cnt = 0;
    int done1_cnt = 0, low1_cnt = 0;
    int b_done, b_low, b_rise, b_fall, b_hi, b_done1, b_low1;
    int n_checks = 0, n_errors = 0;
    bit seen;

    assign din = din_sel ? dout : s_din;

    spi_master #(.DATA_WIDTH(16), .HALF_DIV(4)) u_dut (
        .clk(clk), .rstb(rstb), .CPOL(CPOL), .CPHA(CPHA), .start(start),
        .datai(datai), .datao(datao), .busy(busy), .done(done),
        .sclk(sclk), .csb(csb), .dout(dout), .din(din)
    );

    spi_master #(.DATA_WIDTH(16), .HALF_DIV(1)) u_dut1 (
        .clk(clk), .rstb(rstb), .CPOL(1'b0), .CPHA(1'b0), .start(start1),
        .datai(datai1), .datao(datao1), .busy(busy1), .done(done1),
        .sclk(sclk1), .csb(csb1), .dout(dout1), .din(din1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done)  done_cnt++;
        if (!csb)  low_cnt++;
        if (csb)   hi_cnt++;
        if (done1) done1_cnt++;
        if (!csb1) low1_cnt++;
    end

    // Behavioural slave plus sclk edge counting while csb is low.
    always @(csb or sclk) begin
        if (csb === 1'b0 && prev_csb === 1'b1) begin
            s_tx    = slave_word;
            s_rx    = '0;
            s_edges = 0;
            s_din   = s_cpha ? 1'b0 : slave_word[15];
        end else if (csb === 1'b0 && sclk !== prev_sclk) begin
            s_edges++;
            if (sclk) rise_cnt++; else fall_cnt++;
            if ((s_edges % 2 == 1) != s_cpha) begin
                s_rx = {s_rx[14:0], dout};
            end else if (s_cpha) begin
                s_din = s_tx[15];
                s_tx  = s_tx << 1;
            end else begin
                s_tx  = s_tx << 1;
                s_din = s_tx[15];
            end
        end
        prev_csb  = csb;
        prev_sclk = sclk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output bit got);
        got = 1'b0;
        for (int i = 0; i < 1000 && !got; i++) begin
            @(negedge clk);
            got = done;
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && busy; i++) @(negedge clk);
        check("busy_drops", 32'(busy), 32'd0);
    endtask

    task automatic snap();
        b_done = done_cnt; b_low = low_cnt; b_rise = rise_cnt; b_fall = fall_cnt;
    endtask

    task automatic frame(input logic [1:0] mode, input logic [15:0] word, input bit scramble);
        bit got;
        CPOL = mode[1]; CPHA = mode[0]; s_cpha = mode[0];
        repeat (2) @(negedge clk);
        datai = word; start = 1'b1;
        snap();
        @(negedge clk);
        start = 1'b0;
        if (scramble) begin
            CPOL = ~mode[1]; CPHA = ~mode[0]; datai = ~word;
        end
        wait_done(got);
        check("done_seen", 32'(got), 32'd1);
        CPOL = mode[1]; CPHA = mode[0];
        wait_idle();
    endtask

    initial begin
        rstb = 1'b0; CPOL = 1'b1; CPHA = 1'b0; start = 1'b0; datai = '0;
        start1 = 1'b0; datai1 = '0; din1 = 1'b0;
        din_sel = 1'b1; s_cpha = 1'b0; slave_word = 16'h1234;
        repeat (3) @(negedge clk);
        check("rst_csb",   32'(csb),   32'd1);
        check("rst_sclk",  32'(sclk),  32'd0);
        check("rst_dout",  32'(dout),  32'd0);
        check("rst_datao", 32'(datao), 32'd0);
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_sclk_cpol1", 32'(sclk), 32'd1);
        CPOL = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_sclk_cpol0", 32'(sclk), 32'd0);

        // Loopback, mode 0
        din_sel = 1'b1;
        frame(2'b00, 16'hA5C3, 1'b0);
        check("lb_datao", 32'(datao), 32'h0000_A5C3);
        check("lb_done_cnt", 32'(done_cnt - b_done), 32'd1);
        check("lb_csb_low", 32'(low_cnt - b_low), 32'd136);
        check("lb_rise", 32'(rise_cnt - b_rise), 32'd16);
        check("lb_fall", 32'(fall_cnt - b_fall), 32'd16);

        // Behavioural slave, all modes, inputs scrambled mid-frame
        din_sel = 1'b0; slave_word = 16'h1234;
        for (int m = 0; m < 4; m++) begin
            logic [1:0] md;
            md = 2'(m);
            frame(md, 16'hBEEF, 1'b1);
            check($sformatf("m%0d_datao", m), 32'(datao), 32'h0000_1234);
            check($sformatf("m%0d_slave_rx", m), 32'(s_rx), 32'h0000_BEEF);
            check($sformatf("m%0d_rise", m), 32'(rise_cnt - b_rise), 32'd16);
            check($sformatf("m%0d_fall", m), 32'(fall_cnt - b_fall), 32'd16);
            check($sformatf("m%0d_csb_low", m), 32'(low_cnt - b_low), 32'd136);
            repeat (2) @(negedge clk);
            check($sformatf("m%0d_sclk_idle", m), 32'(sclk), 32'(md[1]));
        end

        // Start held high across two frames
        din_sel = 1'b1; CPOL = 1'b0; CPHA = 1'b0;
        repeat (2) @(negedge clk);
        snap();
        datai = 16'h0001; start = 1'b1;
        wait_done(seen);
        check("b2b_done1", 32'(seen), 32'd1);
        check("b2b_datao1", 32'(datao), 32'h0000_0001);
        datai = 16'h8000; b_hi = hi_cnt;
        wait_done(seen);
        start = 1'b0;
        check("b2b_done2", 32'(seen), 32'd1);
        check("b2b_datao2", 32'(datao), 32'h0000_8000);
        check("b2b_csb_high", 32'(hi_cnt - b_hi), 32'd5);
        wait_idle();
        check("b2b_done_cnt", 32'(done_cnt - b_done), 32'd2);

        // Start pulses while busy are ignored
        snap();
        datai = 16'h6B1D; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        datai = 16'hFFFF; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(seen);
        check("ign_datao", 32'(datao), 32'h0000_6B1D);
        wait_idle();
        repeat (10) @(negedge clk);
        check("ign_done_cnt", 32'(done_cnt - b_done), 32'd1);
        check("ign_csb", 32'(csb), 32'd1);

        // Reset at XFER edge 7
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        repeat (2) @(negedge clk);
        snap();
        datai = 16'h5A5A; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 200 && (rise_cnt - b_rise + fall_cnt - b_fall) < 7; i++) @(negedge clk);
        check("rst_edge7_reached", 32'(rise_cnt - b_rise + fall_cnt - b_fall), 32'd7);
        rstb = 1'b0;
        #1;
        check("mid_rst_csb",   32'(csb),   32'd1);
        check("mid_rst_sclk",  32'(sclk),  32'd0);
        check("mid_rst_datao", 32'(datao), 32'd0);
        check("mid_rst_busy",  32'(busy),  32'd0);
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        repeat (20) @(negedge clk);
        check("mid_rst_no_done", 32'(done_cnt - b_done), 32'd0);
        check("mid_rst_datao_kept", 32'(datao), 32'd0);
        frame(2'b11, 16'h3C96, 1'b0);
        check("post_rst_datao", 32'(datao), 32'h0000_3C96);
        check("post_rst_csb_low", 32'(low_cnt - b_low), 32'd136);

        // HALF_DIV=1 instance
        for (int k = 0; k < 2; k++) begin
            bit got;
            datai1 = (k == 0) ? 16'hFFFF : 16'h0000;
            din1   = (k == 0) ? 1'b0 : 1'b1;
            @(negedge clk);
            b_done1 = done1_cnt; b_low1 = low1_cnt;
            start1 = 1'b1;
            @(negedge clk);
            start1 = 1'b0;
            got = 1'b0;
            for (int i = 0; i < 200 && !got; i++) begin
                @(negedge clk);
                got = done1;
            end
            check($sformatf("hd1_done_%0d", k), 32'(got), 32'd1);
            check($sformatf("hd1_datao_%0d", k), 32'(datao1), (k == 0) ? 32'h0 : 32'h0000_FFFF);
            repeat (4) @(negedge clk);
            check($sformatf("hd1_csb_low_%0d", k), 32'(low1_cnt - b_low1), 32'd34);
            check($sformatf("hd1_done_cnt_%0d", k), 32'(done1_cnt - b_done1), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
